ov7670_capture_scaler: RTL

//  Parametrised camera capture front-end: assembles 2-byte pixels from an 8-bit DVP bus (VSYNC/HREF/D),

---
 rtl/ov7670_capture_scaler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ov7670_capture_scaler.sv
// Purpose : OV7670 DVP capture front-end. Assembles 2-byte RGB565 pixels, decimates, crops and emits one RAM write per kept pixel.
// Latency : we rises on the 2nd posedge counted from the edge that samples the pixel's 2nd byte (input register + output register).
// Backpr. : none. The camera cannot be stalled, so the write port must accept one write per cycle.
//
// Ports:
//   i_pclk        camera pixel clock; all logic is on its posedge
//   i_rst         asynchronous active-high reset
//   i_vsync       frame sync (high = vertical blanking)
//   i_href        line valid
//   i_d[7:0]      pixel byte
//   i_enable      capture request; sampled only at frame start
//   o_addr        write address oy*OUT_W+ox
//   o_dout[15:0]  RGB565 write data (black outside the crop window)
//   o_we          one-cycle write strobe per kept pixel
//   o_frame_done  one-cycle pulse at the end of a captured frame
//   o_frame_cnt   captured-frame counter (wraps)
//   o_line_err    sticky bad-line-length flag, cleared at frame start
module ov7670_capture_scaler #(
    parameter int SRC_W     = 640,
    parameter int SRC_H     = 480,
    parameter int DEC_X     = 2,
    parameter int DEC_Y     = 2,
    parameter int ADDR_W    = 17,
    parameter int CROP_L    = 0,
    parameter int CROP_R    = 0,
    parameter int CROP_T    = 0,
    parameter int CROP_B    = 0,
    parameter int BYTE_SWAP = 0
) (
    input  logic              i_pclk,
    input  logic              i_rst,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_d,
    input  logic              i_enable,
    output logic [ADDR_W-1:0] o_addr,
    output logic [15:0]       o_dout,
    output logic              o_we,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt,
    output logic              o_line_err
);
    localparam int OUT_W = SRC_W / DEC_X;
    localparam int OUT_H = SRC_H / DEC_Y;
    localparam int CW    = $clog2(OUT_W + 1);
    localparam int RW    = $clog2(OUT_H + 1);
    localparam int BW    = $clog2(2 * SRC_W + 2);

    localparam logic [CW-1:0] OUT_W_C  = CW'(OUT_W);
    localparam logic [RW-1:0] OUT_H_C  = RW'(OUT_H);
    localparam logic [CW-1:0] CROP_L_C = CW'(CROP_L);
    localparam logic [RW-1:0] CROP_T_C = RW'(CROP_T);
    localparam logic [CW-1:0] WIN_W_C  = CW'(OUT_W - CROP_L - CROP_R);
    localparam logic [RW-1:0] WIN_H_C  = RW'(OUT_H - CROP_T - CROP_B);
    localparam logic [1:0]    DX_M1    = 2'(DEC_X - 1);
    localparam logic [1:0]    DY_M1    = 2'(DEC_Y - 1);
    localparam logic [BW-1:0] LINE_B   = BW'(2 * SRC_W);
    localparam logic [BW-1:0] BCNT_MAX = BW'(2 * SRC_W + 1);

    typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE} state_t;

    state_t            r_state;
    logic              r_vs, r_hr, r_hr_d;
    logic [7:0]        r_d, r_b0;
    logic              r_phase;      // 1 = first byte of a pair is held in r_b0
    logic [1:0]        r_cx, r_cy;   // decimation phase within column / row
    logic [CW-1:0]     r_ox;
    logic [RW-1:0]     r_oy;
    logic [BW-1:0]     r_bcnt;       // saturates so a very long line cannot alias to a good length
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_dout;
    logic              r_we, r_fd, r_le;
    logic [7:0]        r_cnt;

    logic              w_href_rise, w_href_fall, w_second, w_keep, w_inside;
    logic [15:0]       w_pixel;
    logic [ADDR_W-1:0] w_addr;

    assign w_href_rise = r_hr & ~r_hr_d;
    assign w_href_fall = ~r_hr & r_hr_d;
    assign w_second    = r_hr & r_hr_d & r_phase;
    assign w_pixel     = (BYTE_SWAP != 0) ? {r_d, r_b0} : {r_b0, r_d};
    assign w_keep      = w_second && (r_cx == 2'd0) && (r_cy == 2'd0) &&
                         (r_ox < OUT_W_C) && (r_oy < OUT_H_C);
    // Unsigned wrap makes "below the low edge" land above the window width,
    // so each axis needs a single compare.
    assign w_inside    = (CW'(r_ox - CROP_L_C) < WIN_W_C) &&
                         (RW'(r_oy - CROP_T_C) < WIN_H_C);
    assign w_addr      = ADDR_W'(r_oy) * ADDR_W'(OUT_W) + ADDR_W'(r_ox);

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= WAIT_VS;
            r_vs    <= 1'b0;
            r_hr    <= 1'b0;
            r_hr_d  <= 1'b0;
            r_d     <= 8'h00;
            r_b0    <= 8'h00;
            r_phase <= 1'b0;
            r_cx    <= 2'd0;
            r_cy    <= 2'd0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_bcnt  <= '0;
            r_addr  <= '0;
            r_dout  <= 16'h0000;
            r_we    <= 1'b0;
            r_fd    <= 1'b0;
            r_le    <= 1'b0;
            r_cnt   <= 8'h00;
        end else begin
            r_vs   <= i_vsync;
            r_hr   <= i_href;
            r_d    <= i_d;
            r_hr_d <= r_hr;
            r_we   <= 1'b0;
            r_fd   <= 1'b0;
            case (r_state)
                WAIT_VS: begin
                    if (r_vs) r_state <= VBLANK;
                end
                VBLANK: begin
                    if (!r_vs) begin
                        r_cx    <= 2'd0;
                        r_cy    <= 2'd0;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_phase <= 1'b0;
                        r_le    <= 1'b0;
                        r_state <= i_enable ? ACTIVE : WAIT_VS;
                    end
                end
                ACTIVE: begin
                    if (r_vs) begin
                        // vsync rise ends the frame, aborting any partial line
                        r_state <= VBLANK;
                        r_fd    <= 1'b1;
                        r_cnt   <= r_cnt + 8'd1;
                    end else begin
                        if (w_href_rise) begin
                            r_b0    <= r_d;
                            r_phase <= 1'b1;
                            r_bcnt  <= BW'(1);
                        end else if (r_hr) begin
                            if (r_bcnt != BCNT_MAX) r_bcnt <= r_bcnt + BW'(1);
                            if (r_phase) begin
                                r_phase <= 1'b0;
                                r_cx    <= (r_cx == DX_M1) ? 2'd0 : r_cx + 2'd1;
                                if (w_keep) begin
                                    r_addr <= w_addr;
                                    r_dout <= w_inside ? w_pixel : 16'h0000;
                                    r_we   <= 1'b1;
                                    r_ox   <= r_ox + CW'(1);
                                end
                            end else begin
                                r_b0    <= r_d;
                                r_phase <= 1'b1;
                            end
                        end
                        if (w_href_fall) begin
                            r_cx <= 2'd0;
                            r_ox <= '0;
                            r_cy <= (r_cy == DY_M1) ? 2'd0 : r_cy + 2'd1;
                            if (r_cy == 2'd0 && r_oy < OUT_H_C) r_oy <= r_oy + RW'(1);
                            if (r_bcnt != LINE_B) r_le <= 1'b1;
                        end
                    end
                end
                default: r_state <= WAIT_VS;
            endcase
        end
    end

    assign o_addr       = r_addr;
    assign o_dout       = r_dout;
    assign o_we         = r_we;
    assign o_frame_done = r_fd;
    assign o_frame_cnt  = r_cnt;
    assign o_line_err   = r_le;
endmodule
